mem_stage_lsu: RTL and testbench

Memory stage directly downstream of the execute-stage decoder/ALU. It consumes the decoded memory controls (Mem_rw, Mem_val, Wb_sel, Rf_wen), the ALU result and rs2, and drives a req/gnt/rvalid data-memory port. It performs byte-lane steering and load extension. It produces one registered writeback record per accepted instruction and stalls execute while a memory access is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 26 ++
 rtl/mem_stage_lsu_if.sv | 22 ++
 rtl/mem_stage_lsu_align.sv | 64 ++++++
 rtl/mem_stage_lsu.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Contents:
//   MV_*        access size encodings carried on ex_mem_val
//   WB_*        writeback source encodings carried on ex_wb_sel
//   lsu_state_e FSM state codes (also exported on the debug port)
//   TIMEOUT_DEFAULT default watchdog limit in cycles
package mem_stage_lsu_pkg;

  localparam logic [1:0] MV_B = 2'b00;
  localparam logic [1:0] MV_H = 2'b01;
  localparam logic [1:0] MV_W = 2'b11;

  localparam logic [1:0] WB_MEM  = 2'b11;
  localparam logic [1:0] WB_ALU  = 2'b10;
  localparam logic [1:0] WB_PC4  = 2'b01;
  localparam logic [1:0] WB_NONE = 2'b00;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port bundle (req/gnt/rvalid protocol).
// Handshake: the master raises req with we/addr/be/wdata and holds them
// stable until it samples gnt=1 at a rising edge; that edge accepts the
// request. For reads the slave later returns rdata qualified by a
// one-cycle rvalid; rvalid is only meaningful after the grant.
//   master: drives req, we, addr, be, wdata; receives gnt, rvalid, rdata
//   slave : the memory side, opposite directions
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, be, wdata,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic shared by the store and load paths.
// Ports:
//   size, addr_lo        access size and low address bits
//   unsigned_ld          zero-extend (1) or sign-extend (0) loads
//   store_data, rdata    raw store operand and raw bus read data
//   be, wdata            byte enables and lane-replicated store data
//   load_data            extracted and extended load value
//   misalign             access cannot be issued (bad alignment or size)
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[7:0];
    half_sel  = rdata[15:0];
    be        = 4'b0000;
    wdata     = store_data;
    load_data = rdata;
    misalign  = 1'b0;

    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      MV_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
      end
      MV_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
        misalign  = addr_lo[0];
      end
      MV_W: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        misalign  = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: accepts decoded memory controls from execute, runs one
// data-memory access at a time and emits one registered writeback record
// per accepted instruction.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   ex_*              instruction from execute; ex_ready high only in IDLE
//   dmem              data-memory master port (req/gnt/rvalid)
//   wb_*              writeback record, qualified by the one-cycle wb_valid
//   dbg_state         current FSM state
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_mem_en,
  input  logic             ex_mem_rw,
  input  logic [1:0]       ex_mem_val,
  input  logic             ex_mem_unsigned,
  input  logic [1:0]       ex_wb_sel,
  input  logic             ex_rf_wen,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_alu_out,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc4,
  mem_stage_lsu_if.master  dmem,
  output logic             wb_valid,
  output logic             wb_wen,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_misalign,
  output logic             wb_bus_err,
  output lsu_state_e       dbg_state
);

  // Wide enough to hold TIMEOUT itself: a load granted on the last
  // watchdog cycle enters RESP one count past the limit.
  localparam int CW = $clog2(TIMEOUT + 2);

  lsu_state_e      state, state_n;
  logic [CW-1:0]   wd_cnt;
  logic            timeout;

  logic            rw_q, uns_q, rf_wen_q;
  logic [1:0]      size_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q, rs2_q;

  logic            fire, wen_n, mis_n, err_n;
  logic [4:0]      rd_n;
  logic [XLEN-1:0] data_n;

  logic            is_idle;
  logic [1:0]      a_size, a_addr;
  logic [3:0]      a_be;
  logic [31:0]     a_wdata, a_load;
  logic            a_misalign;

  assign is_idle = (state == S_IDLE);

  // In IDLE the aligner looks at the incoming instruction so misalignment
  // is known before committing to a bus request; afterwards it works from
  // the captured copy.
  assign a_size = is_idle ? ex_mem_val      : size_q;
  assign a_addr = is_idle ? ex_alu_out[1:0] : addr_q[1:0];

  mem_stage_lsu_align u_align (
    .size        (a_size),
    .addr_lo     (a_addr),
    .unsigned_ld (uns_q),
    .store_data  (rs2_q),
    .rdata       (dmem.rdata),
    .be          (a_be),
    .wdata       (a_wdata),
    .load_data   (a_load),
    .misalign    (a_misalign)
  );

  assign timeout = (TIMEOUT > 0) && (wd_cnt >= CW'(TIMEOUT - 1));

  assign ex_ready   = is_idle;
  assign dbg_state  = state;
  assign dmem.req   = (state == S_REQ);
  assign dmem.we    = dmem.req & rw_q;
  assign dmem.addr  = dmem.req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem.be    = dmem.req ? a_be : 4'b0000;
  assign dmem.wdata = dmem.req ? a_wdata : 32'd0;

  always_comb begin
    state_n = state;
    fire    = 1'b0;
    wen_n   = 1'b0;
    rd_n    = rd_q;
    data_n  = '0;
    mis_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        rd_n = ex_rd;
        if (ex_valid) begin
          if (!ex_mem_en) begin
            fire  = 1'b1;
            wen_n = ex_rf_wen;
            case (ex_wb_sel)
              WB_ALU:  data_n = ex_alu_out;
              WB_PC4:  data_n = ex_pc4;
              WB_MEM:  data_n = '0;
              WB_NONE: data_n = '0;
              default: data_n = '0;
            endcase
          end else if (a_misalign) begin
            fire  = 1'b1;
            mis_n = 1'b1;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem.gnt) begin
          if (rw_q) begin
            fire    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_RESP;
          end
        end else if (timeout) begin
          fire    = 1'b1;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_RESP: begin
        if (dmem.rvalid) begin
          fire    = 1'b1;
          wen_n   = rf_wen_q;
          data_n  = a_load;
          state_n = S_IDLE;
        end else if (timeout) begin
          fire    = 1'b1;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wd_cnt      <= '0;
      rw_q        <= 1'b0;
      uns_q       <= 1'b0;
      rf_wen_q    <= 1'b0;
      size_q      <= 2'b00;
      rd_q        <= 5'd0;
      addr_q      <= '0;
      rs2_q       <= '0;
      wb_valid    <= 1'b0;
      wb_wen      <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
      wb_misalign <= 1'b0;
      wb_bus_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wb_valid <= fire;
      if (fire) begin
        wb_wen      <= wen_n;
        wb_rd       <= rd_n;
        wb_data     <= data_n;
        wb_misalign <= mis_n;
        wb_bus_err  <= err_n;
      end
      if (is_idle && ex_valid) begin
        rw_q     <= ex_mem_rw;
        uns_q    <= ex_mem_unsigned;
        rf_wen_q <= ex_rf_wen;
        size_q   <= ex_mem_val;
        rd_q     <= ex_rd;
        addr_q   <= ex_alu_out;
        rs2_q    <= ex_rs2;
      end
      if (is_idle && (state_n == S_REQ)) wd_cnt <= '0;
      else if (!is_idle)                 wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: drives execute-side instructions and a
// hand-sequenced memory responder; writeback records are matched against
// an expected queue by a monitor on the falling edge.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int W = 41;  // {chk_data, wen, rd[4:0], data[31:0], mis, err}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_mem_en = 1'b0, ex_mem_rw = 1'b0, ex_mem_unsigned = 1'b0;
  logic [1:0]  ex_mem_val = 2'b00, ex_wb_sel = 2'b00;
  logic        ex_rf_wen = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic [31:0] ex_alu_out = 32'd0, ex_rs2 = 32'd0, ex_pc4 = 32'd0;
  logic        wb_valid, wb_wen, wb_misalign, wb_bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  lsu_state_e  dbg_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_mem_en       (ex_mem_en),
    .ex_mem_rw       (ex_mem_rw),
    .ex_mem_val      (ex_mem_val),
    .ex_mem_unsigned (ex_mem_unsigned),
    .ex_wb_sel       (ex_wb_sel),
    .ex_rf_wen       (ex_rf_wen),
    .ex_rd           (ex_rd),
    .ex_alu_out      (ex_alu_out),
    .ex_rs2          (ex_rs2),
    .ex_pc4          (ex_pc4),
    .dmem            (dmem.master),
    .wb_valid        (wb_valid),
    .wb_wen          (wb_wen),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .wb_misalign     (wb_misalign),
    .wb_bus_err      (wb_bus_err),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench time limit");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [39:0]  obs, expv;
    if (rst_n && wb_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          fails++;
          $error("FAIL wb_unexpected: observed wb_valid=1 expected no record");
        end
      end else begin
        e    = exp_q.pop_front();
        obs  = {wb_wen, wb_rd, wb_data, wb_misalign, wb_bus_err};
        expv = e[39:0];
        if (!e[40]) begin
          obs[38:2]  = '0;
          expv[38:2] = '0;
        end
        assert (obs === expv) else begin
          fails++;
          $error("FAIL wb_record: observed %h expected %h", obs, expv);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic chk, input logic wen, input logic [4:0] rd,
                          input logic [31:0] data, input logic mis, input logic err);
    exp_q.push_back({chk, wen, rd, data, mis, err});
  endtask

  task automatic set_ex(input logic en, input logic rw, input logic [1:0] val,
                        input logic uns, input logic [1:0] sel, input logic wen,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [31:0] pc4);
    ex_valid        = 1'b1;
    ex_mem_en       = en;
    ex_mem_rw       = rw;
    ex_mem_val      = val;
    ex_mem_unsigned = uns;
    ex_wb_sel       = sel;
    ex_rf_wen       = wen;
    ex_rd           = rd;
    ex_alu_out      = alu;
    ex_rs2          = rs2;
    ex_pc4          = pc4;
  endtask

  task automatic clr_ex();
    ex_valid  = 1'b0;
    ex_mem_en = 1'b0;
    ex_alu_out = $urandom();
    ex_rs2     = $urandom();
  endtask

  task automatic do_store(input string tag, input logic [1:0] val, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int gnt_delay);
    set_ex(1'b1, 1'b1, val, 1'b0, WB_NONE, 1'b0, 5'd0, addr, rs2, 32'd0);
    tick();
    clr_ex();
    for (int i = 0; i < gnt_delay; i++) begin
      check({tag, "_req_wait"}, dmem.req, 1'b1);
      check({tag, "_stable"}, {dmem.we, dmem.addr, dmem.be, dmem.wdata},
            {1'b1, addr & 32'hFFFF_FFFC, exp_be, exp_wdata});
      check({tag, "_ready_low"}, ex_ready, 1'b0);
      tick();
    end
    check({tag, "_bus"}, {dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata},
          {2'b11, addr & 32'hFFFF_FFFC, exp_be, exp_wdata});
    dmem.gnt = 1'b1;
    push_exp(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    dmem.gnt = 1'b0;
    check({tag, "_req_drop"}, {dmem.req, ex_ready, wb_valid}, 3'b011);
  endtask

  task automatic do_load(input string tag, input logic [1:0] val, input logic uns,
                         input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] exp_data);
    set_ex(1'b1, 1'b0, val, uns, WB_MEM, 1'b1, rd, addr, 32'd0, 32'd0);
    tick();
    clr_ex();
    check({tag, "_bus"}, {dmem.req, dmem.we, dmem.addr}, {2'b10, addr & 32'hFFFF_FFFC});
    dmem.gnt = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    check({tag, "_resp"}, {dmem.req, ex_ready, dbg_state}, {2'b00, S_RESP});
    dmem.rvalid = 1'b1;
    dmem.rdata  = rdata;
    push_exp(1'b1, 1'b1, rd, exp_data, 1'b0, 1'b0);
    tick();
    dmem.rvalid = 1'b0;
    dmem.rdata  = $urandom();
    check({tag, "_done"}, {wb_valid, ex_ready}, 2'b11);
  endtask

  // directed sequence
  initial begin
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'd0;

    rst_n = 1'b0;
    tick();
    tick();
    check("reset_outputs", {ex_ready, wb_valid, wb_wen, wb_rd, wb_data, wb_misalign, wb_bus_err},
          {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0});
    check("reset_bus", {dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata}, 70'd0);
    check("reset_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    tick();

    // ALU op, then back-to-back pc+4 and none-select ops
    set_ex(1'b0, 1'b0, MV_W, 1'b0, WB_ALU, 1'b1, 5'd5, 32'h0000_1234, 32'd0, 32'h0000_0040);
    push_exp(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
    tick();
    check("alu_no_req", {dmem.req, ex_ready, wb_valid}, 3'b011);
    set_ex(1'b0, 1'b0, MV_W, 1'b0, WB_PC4, 1'b1, 5'd1, 32'hDEAD_BEEF, 32'd0, 32'h0000_0804);
    push_exp(1'b1, 1'b1, 5'd1, 32'h0000_0804, 1'b0, 1'b0);
    tick();
    set_ex(1'b0, 1'b0, MV_W, 1'b0, WB_NONE, 1'b0, 5'd9, 32'h1111_2222, 32'd0, 32'h3);
    push_exp(1'b1, 1'b0, 5'd9, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    clr_ex();
    tick();
    check("alu_pulse_end", wb_valid, 1'b0);

    // stores
    do_store("sb", MV_B, 32'h0000_0102, 32'hAABB_CCDD, 4'b0100, 32'hDDDD_DDDD, 2);
    do_store("sh", MV_H, 32'h0000_0102, 32'h1234_5678, 4'b1100, 32'h5678_5678, 0);
    do_store("sw", MV_W, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);

    // loads
    do_load("lh_s",  MV_H, 1'b0, 32'h0000_0206, 5'd7,  32'h8001_0000, 32'hFFFF_8001);
    do_load("lh_u",  MV_H, 1'b1, 32'h0000_0206, 5'd8,  32'h8001_0000, 32'h0000_8001);
    do_load("lb_s",  MV_B, 1'b0, 32'h0000_0203, 5'd10, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lbu_1", MV_B, 1'b1, 32'h0000_0201, 5'd11, 32'h80F2_9456, 32'h0000_0094);
    do_load("lw",    MV_W, 1'b0, 32'h0000_0200, 5'd12, 32'h89AB_CDEF, 32'h89AB_CDEF);

    // misaligned word, misaligned half, illegal size
    set_ex(1'b1, 1'b0, MV_W, 1'b0, WB_MEM, 1'b1, 5'd3, 32'h0000_0301, 32'd0, 32'd0);
    push_exp(1'b0, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0);
    tick();
    clr_ex();
    check("mis_w", {dmem.req, ex_ready, wb_valid, wb_misalign, wb_wen}, 5'b01110);
    set_ex(1'b1, 1'b1, MV_H, 1'b0, WB_NONE, 1'b0, 5'd0, 32'h0000_0305, 32'h5, 32'd0);
    push_exp(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check("mis_h", dmem.req, 1'b0);
    set_ex(1'b1, 1'b0, 2'b10, 1'b0, WB_MEM, 1'b1, 5'd4, 32'h0000_0300, 32'd0, 32'd0);
    push_exp(1'b0, 1'b0, 5'd4, 32'd0, 1'b1, 1'b0);
    tick();
    clr_ex();
    check("mis_size10", {dmem.req, wb_misalign, wb_bus_err}, 3'b010);
    tick();

    // watchdog: load granted, rvalid never arrives
    set_ex(1'b1, 1'b0, MV_W, 1'b0, WB_MEM, 1'b1, 5'd13, 32'h0000_0400, 32'd0, 32'd0);
    tick();
    clr_ex();
    dmem.gnt = 1'b1;
    push_exp(1'b0, 1'b0, 5'd13, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick();
      dmem.gnt = 1'b0;
      check("wd_waiting", {wb_valid, ex_ready}, 2'b00);
    end
    tick();
    check("wd_bus_err", {wb_valid, wb_bus_err, wb_misalign, wb_wen, ex_ready, dbg_state},
          {5'b11001, S_IDLE});

    // reset while waiting for load data; late rvalid must be ignored
    tick();
    set_ex(1'b1, 1'b0, MV_W, 1'b0, WB_MEM, 1'b1, 5'd14, 32'h0000_0500, 32'd0, 32'd0);
    tick();
    clr_ex();
    dmem.gnt = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    check("rst_in_resp", dbg_state, S_RESP);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_release", {ex_ready, dmem.req, wb_valid, wb_data, wb_bus_err}, {3'b100, 32'd0, 1'b0});
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h5555_AAAA;
    tick();
    dmem.rvalid = 1'b0;
    check("rst_ignore_rvalid", {wb_valid, wb_wen, wb_data, dbg_state}, {2'b00, 32'd0, S_IDLE});
    set_ex(1'b0, 1'b0, MV_W, 1'b0, WB_ALU, 1'b1, 5'd15, 32'h0BAD_F00D, 32'd0, 32'd0);
    push_exp(1'b1, 1'b1, 5'd15, 32'h0BAD_F00D, 1'b0, 1'b0);
    tick();
    clr_ex();
    check("post_rst_alu", {wb_valid, wb_data}, {1'b1, 32'h0BAD_F00D});

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check("queue_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
